// File: rtl/ccff_loader.sv
// Serialises bitstream words onto a configuration chain head with a gated shift enable.
// Define CCFF_LOADER_READBACK_EN to build the CRC-16-CCITT over bits returning on ccff_tail.
module ccff_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1024
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ccff_head,
  output logic              chain_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [15:0]       readback_crc
);

  localparam int BL_W = $clog2(CHAIN_LEN + 1);
  localparam int WB_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [WORD_W-1:0] sreg, sreg_d;
  logic [BL_W-1:0]   bits_left, bits_left_d;
  logic [WB_W-1:0]   word_bits_left, word_bits_left_d;
  logic              in_ready_d;
  logic              ccff_head_d;
  logic              chain_shift_en_d;
  logic              busy_d;
  logic              done_d;
  logic              handshake;

  assign handshake = in_valid & in_ready;

  always_comb begin
    state_d          = state;
    sreg_d           = sreg;
    bits_left_d      = bits_left;
    word_bits_left_d = word_bits_left;
    ccff_head_d      = ccff_head;
    chain_shift_en_d = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d          = LOAD;
          sreg_d           = '0;
          bits_left_d      = BL_W'(CHAIN_LEN);
          word_bits_left_d = '0;
        end
      end
      LOAD: begin
        if (handshake) begin
          sreg_d           = in_data;
          word_bits_left_d = WB_W'(WORD_W);
          state_d          = SHIFT;
        end
      end
      SHIFT: begin
        ccff_head_d      = sreg[0];
        chain_shift_en_d = 1'b1;
        sreg_d           = {1'b0, sreg[WORD_W-1:1]};
        bits_left_d      = bits_left - BL_W'(1);
        word_bits_left_d = word_bits_left - WB_W'(1);
        if (bits_left == BL_W'(1)) begin
          state_d = DONE;
        end else if (word_bits_left == WB_W'(1)) begin
          // Reloading on the last bit of a word keeps the enable stream bubble-free.
          if (handshake) begin
            sreg_d           = in_data;
            word_bits_left_d = WB_W'(WORD_W);
          end else begin
            state_d = LOAD;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // in_ready is registered, so it is derived from the state being entered.
    in_ready_d = (state_d == LOAD) ||
                 ((state_d == SHIFT) && (word_bits_left_d == WB_W'(1)) &&
                  (bits_left_d > BL_W'(1)));
    busy_d     = (state_d != IDLE);
    done_d     = (state == DONE);
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state          <= IDLE;
      sreg           <= '0;
      bits_left      <= '0;
      word_bits_left <= '0;
      in_ready       <= 1'b0;
      ccff_head      <= 1'b0;
      chain_shift_en <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_d;
      sreg           <= sreg_d;
      bits_left      <= bits_left_d;
      word_bits_left <= word_bits_left_d;
      in_ready       <= in_ready_d;
      ccff_head      <= ccff_head_d;
      chain_shift_en <= chain_shift_en_d;
      busy           <= busy_d;
      done           <= done_d;
    end
  end

`ifdef CCFF_LOADER_READBACK_EN
  logic [15:0] crc_q;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    crc16_step = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // The tail bit is meaningful on the same cycles the chain is being clocked.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      crc_q <= 16'h0000;
    end else if ((state == IDLE) && start) begin
      crc_q <= 16'hFFFF;
    end else if (chain_shift_en) begin
      crc_q <= crc16_step(crc_q, ccff_tail);
    end
  end

  assign readback_crc = crc_q;
`else
  logic unused_tail;
  assign unused_tail  = ccff_tail;
  assign readback_crc = 16'h0000;
`endif

endmodule

// File: doc/ccff_loader.md
# ccff_loader

Upstream feeder for the configuration-chain (ccff) ports of the routing/logic tiles. It accepts bitstream words over a valid/ready stream and serialises them onto `ccff_head` of the first tile in the chain. It also emits a shift-enable for the downstream `prog_clk` gate, so the chain only advances when a valid bit is presented. An optional CRC of bits returning on `ccff_tail` supports readback checking.

## Interface
- `WORD_W`, 32: input word width (≥2).
- `CHAIN_LEN`, 1024: total configuration bits in the chain (≥1); the number of shifts per load.
- `prog_clk`  in  1: configuration clock; every flop in this block is on it.
- `prog_reset`  in  1: synchronous, active-high reset.
- `start`  in  1: single-cycle pulse that begins a load; ignored while `busy`.
- `in_data`  in  WORD_W: bitstream word; bit 0 is shifted first.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: the word is accepted on the cycle where `in_valid & in_ready`.
- `ccff_head`  out  1: serial bit to the chain head; registered.
- `chain_shift_en`  out  1: registered enable to the chain's clock gate; the chain samples `ccff_head` on the edge after this is high.
- `ccff_tail`  in  1: serial bit returning from the chain tail.
- `busy`  out  1: high from the cycle after `start` until `done`.
- `done`  out  1: one-cycle pulse after the final shift.
- `readback_crc`  out  16: CRC of the tail bits (see Configuration).

## Operation
- States:
  - IDLE: `start` → LOAD. Clears the bit counter, word store and CRC.
  - LOAD: `in_ready`=1. On handshake, capture the word → SHIFT.
  - SHIFT: present one bit per cycle. When the word empties and bits remain → LOAD behaviour, with the same-cycle reload rule below. When `bits_left` reaches 0 → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- Shift register `sreg[WORD_W-1:0]` and counter `word_bits_left`. Each shift cycle:
  - `ccff_head` <= `sreg[0]`, `chain_shift_en` <= 1.
  - `sreg` shifts right.
  - `bits_left` and `word_bits_left` decrement.
- `bits_left` is `$clog2(CHAIN_LEN+1)` bits wide and is loaded with CHAIN_LEN at `start`.
- Zero-bubble streaming: `in_ready` is asserted in SHIFT on the cycle where `word_bits_left`==1 and `bits_left`>1. A handshake on that cycle reloads `sreg`, so the next cycle shifts bit 0 of the new word.
- Stall: if a bit is needed and no word is held, `chain_shift_en` <= 0 and all counters hold. `in_ready` stays high until the handshake.
- Final word: only the `bits_left` remaining low bits are shifted. The upper bits are discarded and `in_ready` is not re-asserted.
- No more than ⌈CHAIN_LEN/WORD_W⌉ words are accepted per load. `in_ready`=0 in IDLE and DONE.
- `start` while `busy` is ignored. `in_valid` outside a load is ignored.
- `prog_reset`: next state is IDLE.
  - `ccff_head`, `chain_shift_en`, `in_ready`, `busy`, `done` and `readback_crc` are all 0.
  - Counters and `sreg` are cleared.
  - This applies mid-load as well: the partial chain contents are abandoned.

## Timing
- `start` at cycle t → `busy` and `in_ready` high at t+1.
- With `in_valid` continuously high, the first `chain_shift_en` is at t+3. There are then exactly CHAIN_LEN consecutive enable cycles, and `done` follows at the cycle after the last enable.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- The `ccff_tail` sample for the CRC is taken on every cycle where `chain_shift_en`=1.

## Configuration
- `CCFF_LOADER_READBACK_EN` defined:
  - `readback_crc` is a CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first update, no final XOR) over each `ccff_tail` bit sampled while `chain_shift_en`=1.
  - It is reset to 0xFFFF on `start` and is valid from `done` until the next `start`.
- Undefined: no CRC logic is built, `readback_crc` is tied to 16'h0000, and `ccff_tail` is unused.

## Test plan
- Reset: assert `prog_reset` for 2 cycles mid-SHIFT → on the next cycle all outputs are 0 and the state is IDLE. A new `start` with `CHAIN_LEN`=8 then completes 8 shifts.
- `CHAIN_LEN`=8, `WORD_W`=32, `in_data`=0x000000A5:
  - `chain_shift_en` is high for 8 consecutive cycles.
  - `ccff_head` sequence is 1,0,1,0,0,1,0,1.
  - Exactly one handshake occurs; `done` pulses once.
- `CHAIN_LEN`=40, words 0xFFFFFFFF then 0x000000F0 with `in_valid` held high:
  - 40 contiguous enable cycles with no bubble.
  - The last 8 head bits are 0,0,0,0,1,1,1,1.
  - Exactly 2 handshakes.
- Stall: same stimulus as the previous case, with `in_valid` low for 3 cycles before the second word → `chain_shift_en` is low for exactly 3 cycles and the total enable count is still 40.
- `start` pulsed while `busy`, plus `in_valid` high in IDLE → no extra handshake, no restart, and the enable count is unchanged.
- With the macro, `CHAIN_LEN`=8, `ccff_tail` held 1 → after `done`, `readback_crc` equals the golden-model CRC-16-CCITT of eight 1 bits (init 0xFFFF). Without the macro → `readback_crc`=0x0000.
